// File: rtl/fns_encoder_seq_if.sv
// fns_encoder_seq_if: input/output handshake bundle for the Zeckendorf encoder
interface fns_encoder_seq_if #(
    parameter int CW_W   = 10,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW_W-1:0]   out_cw;
    logic              out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_cw, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_cw, out_err
    );
endinterface

// File: rtl/fns_encoder_seq.sv
// fns_encoder_seq: greedy MSB-first Zeckendorf encoder, one codeword bit per cycle
module fns_encoder_seq #(
    parameter int CW_W   = 10,
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    fns_encoder_seq_if.slave bus
);
    function automatic int fib(input int n);
        int a, b, t;
        a = 0;
        b = 1;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam int                IW     = $clog2(CW_W);
    localparam logic [DATA_W-1:0] MAXV   = DATA_W'(fib(CW_W + 2) - 1);
    localparam logic [DATA_W-1:0] W_HI0  = DATA_W'(fib(CW_W + 1));
    localparam logic [DATA_W-1:0] W_LO0  = DATA_W'(fib(CW_W));
    localparam logic [IW-1:0]     IDX0   = IW'(CW_W - 1);

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] rem, rem_d;
    logic [DATA_W-1:0] w_hi, w_hi_d;
    logic [DATA_W-1:0] w_lo, w_lo_d;
    logic [IW-1:0]     idx, idx_d;
    logic [CW_W-1:0]   cw, cw_d;
    logic              err, err_d;
    logic              take;
    logic              over;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            w_hi  <= '0;
            w_lo  <= '0;
            idx   <= '0;
            cw    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            rem   <= rem_d;
            w_hi  <= w_hi_d;
            w_lo  <= w_lo_d;
            idx   <= idx_d;
            cw    <= cw_d;
            err   <= err_d;
        end
    end

    assign take = rem >= w_hi;
    assign over = bus.in_data > MAXV;

    // Weights walk the Fibonacci recurrence backwards: (hi, lo) -> (lo, hi - lo)
    always_comb begin
        state_d = state;
        rem_d   = rem;
        w_hi_d  = w_hi;
        w_lo_d  = w_lo;
        idx_d   = idx;
        cw_d    = cw;
        err_d   = err;
        if (state == IDLE && bus.in_valid) begin
            state_d = over ? DONE : ENC;
            rem_d   = bus.in_data;
            w_hi_d  = W_HI0;
            w_lo_d  = W_LO0;
            idx_d   = IDX0;
            cw_d    = '0;
            err_d   = over;
        end else if (state == ENC) begin
            cw_d[idx] = take;
            rem_d     = take ? rem - w_hi : rem;
            w_hi_d    = w_lo;
            w_lo_d    = w_hi - w_lo;
            idx_d     = idx - 1'b1;
            state_d   = idx == '0 ? DONE : ENC;
        end else if (state == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_cw    = cw;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_fns_encoder_seq.sv
// tb_fns_encoder_seq: directed vectors with a queue scoreboard and independent output monitor
module tb_fns_encoder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fns_encoder_seq_if #(.CW_W(10), .DATA_W(8)) bus();
    fns_encoder_seq #(.CW_W(10), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [9:0] cw;
        logic       err;
        int         acc;
        int         d;
    } exp_t;

    exp_t q[$];
    int vecs = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;
    int fibw[10] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [9:0] model(input int v);
        logic [9:0] c;
        c = '0;
        for (int i = 9; i >= 0; i--) begin
            if (v >= fibw[i]) begin
                c[i] = 1'b1;
                v -= fibw[i];
            end
        end
        return c;
    endfunction

    task automatic send(input logic [7:0] d, input logic [9:0] ecw, input logic eerr, input bit push);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) q.push_back('{ecw, eerr, cyc, int'(d)});
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
    endtask

    // Monitor: one pop per presented codeword, stability checks while it is held
    exp_t       e;
    logic       checked = 1'b0;
    logic [9:0] hcw;
    logic       herr;
    int         s;
    always @(negedge clk) begin
        if (!rst_n) begin
            checked = 1'b0;
        end else if (bus.out_valid) begin
            if (!checked) begin
                if (q.size() == 0) begin
                    vecs++;
                    fails++;
                    $display("FAIL unexpected_output: got cw=%b err=%b, expected no output", bus.out_cw, bus.out_err);
                end else begin
                    e = q.pop_front();
                    check("out_cw", bus.out_cw, e.cw);
                    check("out_err", bus.out_err, e.err);
                    if (e.err) begin
                        check("err_latency_le1", (cyc - e.acc) <= 1, 1);
                    end else begin
                        check("latency", cyc - e.acc, 10);
                        s = 0;
                        for (int i = 0; i < 10; i++) if (bus.out_cw[i]) s += fibw[i];
                        check("cw_sum", s, e.d);
                        check("no_adjacent_ones", bus.out_cw & (bus.out_cw >> 1), 0);
                    end
                end
                hcw = bus.out_cw;
                herr = bus.out_err;
                checked = 1'b1;
            end else begin
                check("hold_cw", bus.out_cw, hcw);
                check("hold_err", bus.out_err, herr);
            end
            if (bus.out_ready) checked = 1'b0;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_cw", bus.out_cw, 0);
        check("rst_out_err", bus.out_err, 0);
        rst_n = 1'b1;

        send(8'd0,   10'b0000000000, 1'b0, 1'b1);
        send(8'd143, 10'b1010101010, 1'b0, 1'b1);
        send(8'd100, 10'b1000010100, 1'b0, 1'b1);
        send(8'd144, 10'b0000000000, 1'b1, 1'b1);
        send(8'd255, 10'b0000000000, 1'b1, 1'b1);
        send(8'd3,   10'b0000000100, 1'b0, 1'b1);
        drain();

        // Backpressure: hold the result while in_valid pulses are ignored
        bus.out_ready = 1'b0;
        send(8'd7, 10'b0000001010, 1'b0, 1'b1);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid", bus.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_valid_held", bus.out_valid, 1);
            bus.in_valid = k[0];
            bus.in_data  = 8'd42;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", bus.in_ready, 1);
        drain();

        // Reset while resolving idx=4 discards the word
        send(8'd77, 10'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_cw", bus.out_cw, 0);
        check("midrst_out_err", bus.out_err, 0);
        rst_n = 1'b1;
        send(8'd55, 10'b0100000000, 1'b0, 1'b1);
        drain();

        for (int v = 0; v <= 143; v++) begin
            prev = last_acc;
            send(8'(v), model(v), 1'b0, 1'b1);
            if (v > 0) check("accept_spacing", last_acc - prev, 12);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
